// File: rtl/tmds_word_aligner.sv
// tmds_word_aligner
//   Word aligner for one TMDS channel. Sits between a 1:10 deserializer
//   (arbitrary word boundary) and the TMDS decoder. It hunts for the bit
//   offset at which HDMI control tokens appear. Once enough consecutive
//   tokens are seen, it emits word-aligned symbols.
//
// Parameters
//   LOCK_TOKENS  consecutive control tokens needed to declare lock (>=2)
//   TIMEOUT      cycles without a control token before the offset advances
//                (SEARCH) or lock is dropped (LOCKED); must exceed one line
//
// Ports
//   i_pixclk   pixel clock, all logic on rising edge
//   i_reset    asynchronous active-high reset
//   i_raw      raw deserialized word, bit0 = first bit on the wire
//   o_data     aligned symbol, bit0 = first bit of the symbol (2-cycle latency)
//   o_offset   current bit offset 0..9
//   o_aligned  1 while LOCKED
//   o_token    o_data is one of the four control tokens
//   o_resync   one-cycle pulse when lock is lost
module tmds_word_aligner #(
  parameter int LOCK_TOKENS = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic       i_pixclk,
  input  logic       i_reset,
  input  logic [9:0] i_raw,
  output logic [9:0] o_data,
  output logic [3:0] o_offset,
  output logic       o_aligned,
  output logic       o_token,
  output logic       o_resync
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_TOKENS - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_prev;
  logic [3:0]    r_offset, w_off_nxt, w_off_adv;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [RW-1:0] r_run, w_run_nxt;
  logic          r_aligned, r_resync, w_resync_nxt;
  logic [9:0]    r_data;
  logic          r_token;

  logic [19:0]   w_window;
  logic [9:0]    w_cand;
  logic          w_tok;

  // The window spans the previous and current word so that any of the 10 bit
  // offsets yields a complete symbol. The registered offset drives the select
  // directly, so a new offset is used on the very next compare.
  assign w_window = {i_raw, r_prev};
  assign w_cand   = w_window[{1'b0, r_offset} +: 10];
  assign w_tok    = (w_cand == 10'h354) || (w_cand == 10'h0AB) ||
                    (w_cand == 10'h154) || (w_cand == 10'h2AB);

  assign w_off_adv = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_tmo_nxt    = r_tmo;
    w_run_nxt    = r_run;
    w_off_nxt    = r_offset;
    w_resync_nxt = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_tok) begin
          w_state_nxt = VERIFY;
          w_run_nxt   = RW'(1);
          w_tmo_nxt   = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_off_nxt = w_off_adv;
          w_tmo_nxt = '0;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      VERIFY: begin
        if (w_tok) begin
          if (r_run == RUN_LAST) begin
            w_state_nxt = LOCKED;
            w_run_nxt   = RW'(LOCK_TOKENS);
            w_tmo_nxt   = '0;
          end else begin
            w_run_nxt = r_run + RW'(1);
          end
        end else begin
          // Any break in the run means this offset is wrong; try the next one.
          w_state_nxt = SEARCH;
          w_off_nxt   = w_off_adv;
          w_run_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      end
      LOCKED: begin
        // Only a full timeout drops lock; stray data words are expected
        // during active video.
        if (w_tok) begin
          w_tmo_nxt = '0;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt  = SEARCH;
          w_tmo_nxt    = '0;
          w_run_nxt    = '0;
          w_resync_nxt = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_tmo_nxt   = '0;
        w_run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= SEARCH;
      r_prev    <= '0;
      r_offset  <= '0;
      r_tmo     <= '0;
      r_run     <= '0;
      r_aligned <= 1'b0;
      r_resync  <= 1'b0;
      r_data    <= '0;
      r_token   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= i_raw;
      r_offset  <= w_off_nxt;
      r_tmo     <= w_tmo_nxt;
      r_run     <= w_run_nxt;
      r_aligned <= (w_state_nxt == LOCKED);
      r_resync  <= w_resync_nxt;
      r_data    <= w_cand;
      r_token   <= w_tok;
    end
  end

  assign o_data    = r_data;
  assign o_offset  = r_offset;
  assign o_aligned = r_aligned;
  assign o_token   = r_token;
  assign o_resync  = r_resync;

endmodule
